// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants and types for the stage-3 16-bit processor
//            control unit: opcodes, extension codes, condition codes, ALU
//            operation codes, PSR flag indices and the control FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Major opcodes, instruction bits [15:12]
    localparam logic [3:0] c_OP_RTYPE = 4'b0000;
    localparam logic [3:0] c_OP_MEM   = 4'b0100;
    localparam logic [3:0] c_OP_LSHI  = 4'b1000;
    localparam logic [3:0] c_OP_BCOND = 4'b1100;
    localparam logic [3:0] c_OP_MOVI  = 4'b1101;
    localparam logic [3:0] c_OP_LUI   = 4'b1111;

    // R-type extension codes, instruction bits [7:4]
    localparam logic [3:0] c_EXT_AND = 4'b0001;
    localparam logic [3:0] c_EXT_OR  = 4'b0010;
    localparam logic [3:0] c_EXT_XOR = 4'b0011;
    localparam logic [3:0] c_EXT_ADD = 4'b0101;
    localparam logic [3:0] c_EXT_SUB = 4'b1001;
    localparam logic [3:0] c_EXT_CMP = 4'b1011;
    localparam logic [3:0] c_EXT_MOV = 4'b1101;

    // Memory / jump extension codes (opcode 0100)
    localparam logic [3:0] c_EXT_LOAD  = 4'b0000;
    localparam logic [3:0] c_EXT_STOR  = 4'b0100;
    localparam logic [3:0] c_EXT_JCOND = 4'b1100;
    localparam logic [3:0] c_EXT_JAL   = 4'b1000;

    // Condition codes carried in the rd field of jumps and branches
    localparam logic [3:0] c_CC_EQ = 4'b0000;
    localparam logic [3:0] c_CC_NE = 4'b0001;
    localparam logic [3:0] c_CC_CS = 4'b0010;
    localparam logic [3:0] c_CC_CC = 4'b0011;
    localparam logic [3:0] c_CC_GT = 4'b0110;
    localparam logic [3:0] c_CC_LE = 4'b0111;
    localparam logic [3:0] c_CC_LT = 4'b1100;
    localparam logic [3:0] c_CC_GE = 4'b1101;
    localparam logic [3:0] c_CC_UC = 4'b1110;

    // ALU operation codes driven on alu_op
    localparam logic [4:0] c_ALU_NOP = 5'd0;
    localparam logic [4:0] c_ALU_AND = 5'd1;
    localparam logic [4:0] c_ALU_OR  = 5'd2;
    localparam logic [4:0] c_ALU_XOR = 5'd3;
    localparam logic [4:0] c_ALU_ADD = 5'd4;
    localparam logic [4:0] c_ALU_SUB = 5'd5;
    localparam logic [4:0] c_ALU_CMP = 5'd6;
    localparam logic [4:0] c_ALU_MOV = 5'd7;
    localparam logic [4:0] c_ALU_SLL = 5'd8;
    localparam logic [4:0] c_ALU_SRL = 5'd9;

    // PSR / ALU flag bit positions, {C,L,F,Z,N} in [4:0]
    localparam int c_FLAG_C = 4;
    localparam int c_FLAG_L = 3;
    localparam int c_FLAG_F = 2;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_N = 0;

    // Flag update masks
    localparam logic [4:0] c_FLAGS_ARITH = 5'b10100;
    localparam logic [4:0] c_FLAGS_CMP   = 5'b01011;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Decoded instruction classes
    typedef enum logic [3:0] {
        IC_NOP   = 4'd0,
        IC_ALU   = 4'd1,
        IC_CMP   = 4'd2,
        IC_MOVI  = 4'd3,
        IC_LUI   = 4'd4,
        IC_LSHI  = 4'd5,
        IC_LOAD  = 4'd6,
        IC_STOR  = 4'd7,
        IC_JCOND = 4'd8,
        IC_JAL   = 4'd9,
        IC_BCOND = 4'd10
    } iclass_t;

    // Sign-extend an 8-bit branch displacement to 16 bits
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Evaluates a 4-bit branch condition code against PSR flags.
// Revision : 1.0 - initial release
// ============================================================================
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic       i_flag_c,
    input  logic       i_flag_z,
    input  logic       i_flag_n,
    output logic       o_taken
);

    // Map each condition code onto its flag expression; unknown codes never take
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            c_CC_EQ: o_taken = i_flag_z;
            c_CC_NE: o_taken = ~i_flag_z;
            c_CC_CS: o_taken = i_flag_c;
            c_CC_CC: o_taken = ~i_flag_c;
            c_CC_GT: o_taken = ~i_flag_n & ~i_flag_z;
            c_CC_LE: o_taken = i_flag_n | i_flag_z;
            c_CC_LT: o_taken = i_flag_n;
            c_CC_GE: o_taken = ~i_flag_n;
            c_CC_UC: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fsm
// Purpose  : Multicycle control unit. Fetches from BRAM port A, decodes,
//            drives register file / ALU / BRAM port B controls, keeps the
//            PSR and computes the next PC for the external PC register.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_fsm
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pc_in,
    output logic              pc_en,
    output logic [15:0]       pc_next,
    input  logic [15:0]       imem_dout,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_din,
    input  logic [15:0]       dmem_dout,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [15:0]       rf_wdata,
    output logic [3:0]        rf_ra_addr,
    output logic [3:0]        rf_rb_addr,
    input  logic [15:0]       rf_ra_data,
    input  logic [15:0]       rf_rb_data,
    output logic [4:0]        alu_op,
    output logic [4:0]        alu_shamt,
    output logic              alu_flags_en,
    output logic [4:0]        alu_flags_sel,
    output logic              alu_cin,
    input  logic [15:0]       alu_out,
    input  logic [4:0]        alu_flags,
    output logic [15:0]       ir_out
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_ir;
    logic [4:0]  r_psr;

    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_ext;
    logic [3:0]  w_rs;
    logic [7:0]  w_imm8;

    iclass_t     w_cls;
    logic [4:0]  w_dec_alu_op;
    logic [4:0]  w_dec_flags_sel;
    logic        w_taken;
    logic [15:0] w_pc_inc;
    logic [15:0] w_pc_br;

    assign w_op   = r_ir[15:12];
    assign w_rd   = r_ir[11:8];
    assign w_ext  = r_ir[7:4];
    assign w_rs   = r_ir[3:0];
    assign w_imm8 = r_ir[7:0];

    assign w_pc_inc = pc_in + 16'd1;
    assign w_pc_br  = pc_in + sext8(w_imm8);

    // Branch/jump condition is judged against the PSR as it stood before EXEC
    cond_eval u_cond_eval (
        .i_cond   (w_rd),
        .i_flag_c (r_psr[c_FLAG_C]),
        .i_flag_z (r_psr[c_FLAG_Z]),
        .i_flag_n (r_psr[c_FLAG_N]),
        .o_taken  (w_taken)
    );

    // Classify the held instruction and pick its ALU operation and flag mask
    always_comb begin
        w_cls           = IC_NOP;
        w_dec_alu_op    = c_ALU_NOP;
        w_dec_flags_sel = 5'b00000;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_ext)
                    c_EXT_AND: begin w_cls = IC_ALU; w_dec_alu_op = c_ALU_AND; end
                    c_EXT_OR:  begin w_cls = IC_ALU; w_dec_alu_op = c_ALU_OR;  end
                    c_EXT_XOR: begin w_cls = IC_ALU; w_dec_alu_op = c_ALU_XOR; end
                    c_EXT_MOV: begin w_cls = IC_ALU; w_dec_alu_op = c_ALU_MOV; end
                    c_EXT_ADD: begin
                        w_cls           = IC_ALU;
                        w_dec_alu_op    = c_ALU_ADD;
                        w_dec_flags_sel = c_FLAGS_ARITH;
                    end
                    c_EXT_SUB: begin
                        w_cls           = IC_ALU;
                        w_dec_alu_op    = c_ALU_SUB;
                        w_dec_flags_sel = c_FLAGS_ARITH;
                    end
                    c_EXT_CMP: begin
                        w_cls           = IC_CMP;
                        w_dec_alu_op    = c_ALU_CMP;
                        w_dec_flags_sel = c_FLAGS_CMP;
                    end
                    default: w_cls = IC_NOP;
                endcase
            end
            c_OP_MOVI:  w_cls = IC_MOVI;
            c_OP_LUI:   w_cls = IC_LUI;
            c_OP_LSHI: begin
                // Only ext[3:1]=000 is a shift; ext[0] picks the direction
                if (w_ext[3:1] == 3'b000) begin
                    w_cls        = IC_LSHI;
                    w_dec_alu_op = w_ext[0] ? c_ALU_SRL : c_ALU_SLL;
                end
            end
            c_OP_MEM: begin
                case (w_ext)
                    c_EXT_LOAD:  w_cls = IC_LOAD;
                    c_EXT_STOR:  w_cls = IC_STOR;
                    c_EXT_JCOND: w_cls = IC_JCOND;
                    c_EXT_JAL:   w_cls = IC_JAL;
                    default:     w_cls = IC_NOP;
                endcase
            end
            c_OP_BCOND: w_cls = IC_BCOND;
            default:    w_cls = IC_NOP;
        endcase
    end

    // Next-state and control outputs; everything is forced low while in reset
    always_comb begin
        w_state_next  = r_state;
        pc_en         = 1'b0;
        pc_next       = w_pc_inc;
        imem_en       = 1'b0;
        imem_addr     = pc_in[ADDR_W-1:0];
        dmem_en       = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = rf_rb_data[ADDR_W-1:0];
        dmem_din      = rf_ra_data;
        rf_we         = 1'b0;
        rf_waddr      = w_rd;
        rf_wdata      = alu_out;
        rf_ra_addr    = w_rd;
        rf_rb_addr    = w_rs;
        alu_op        = w_dec_alu_op;
        alu_shamt     = {1'b0, w_imm8[3:0]};
        alu_flags_en  = 1'b0;
        alu_flags_sel = 5'b00000;
        alu_cin       = r_psr[c_FLAG_C];
        ir_out        = r_ir;

        case (r_state)
            ST_FETCH: begin
                imem_en      = 1'b1;
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                pc_en         = 1'b1;
                w_state_next  = ST_FETCH;
                alu_flags_en  = (w_dec_flags_sel != 5'b00000);
                alu_flags_sel = w_dec_flags_sel;
                case (w_cls)
                    IC_ALU, IC_LSHI: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_out;
                    end
                    IC_MOVI: begin
                        rf_we    = 1'b1;
                        rf_wdata = {8'h00, w_imm8};
                    end
                    IC_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = {w_imm8, 8'h00};
                    end
                    IC_LOAD: begin
                        // PC update is deferred to WB once the data returns
                        pc_en        = 1'b0;
                        dmem_en      = 1'b1;
                        w_state_next = ST_MEM;
                    end
                    IC_STOR: begin
                        dmem_en = 1'b1;
                        dmem_we = 1'b1;
                    end
                    IC_JCOND: begin
                        if (w_taken) begin
                            pc_next = rf_rb_data;
                        end
                    end
                    IC_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = w_pc_inc;
                        pc_next  = rf_rb_data;
                    end
                    IC_BCOND: begin
                        if (w_taken) begin
                            pc_next = w_pc_br;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                w_state_next = ST_WB;
            end
            ST_WB: begin
                rf_we        = 1'b1;
                rf_wdata     = dmem_dout;
                pc_en        = 1'b1;
                w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_FETCH;
        endcase

        // Gating here means a reset landing mid-instruction writes nothing
        if (rst) begin
            pc_en         = 1'b0;
            pc_next       = 16'h0000;
            imem_en       = 1'b0;
            imem_addr     = '0;
            dmem_en       = 1'b0;
            dmem_we       = 1'b0;
            dmem_addr     = '0;
            dmem_din      = 16'h0000;
            rf_we         = 1'b0;
            rf_waddr      = 4'h0;
            rf_wdata      = 16'h0000;
            rf_ra_addr    = 4'h0;
            rf_rb_addr    = 4'h0;
            alu_op        = 5'b00000;
            alu_shamt     = 5'b00000;
            alu_flags_en  = 1'b0;
            alu_flags_sel = 5'b00000;
            alu_cin       = 1'b0;
            ir_out        = 16'h0000;
        end
    end

    // State register and instruction register (IR captures fetch data in DECODE)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_DECODE) begin
                r_ir <= imem_dout;
            end
        end
    end

    // PSR: only the flags selected by the ALU mask are refreshed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_psr <= 5'b00000;
        end else if (alu_flags_en) begin
            r_psr <= (r_psr & ~alu_flags_sel) | (alu_flags & alu_flags_sel);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cpu_fsm
// Purpose  : Self-checking bench for cpu_fsm with a behavioural datapath
//            (PC register, BRAM, register file, ALU) and an ISA-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_fsm;
    import cpu_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst    = 1'b1;
    logic              tb_clr = 1'b1;
    logic [15:0]       pc_in;
    logic              pc_en;
    logic [15:0]       pc_next;
    logic [15:0]       imem_dout;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic              dmem_en;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [15:0]       dmem_din;
    logic [15:0]       dmem_dout;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [15:0]       rf_wdata;
    logic [3:0]        rf_ra_addr;
    logic [3:0]        rf_rb_addr;
    logic [15:0]       rf_ra_data;
    logic [15:0]       rf_rb_data;
    logic [4:0]        alu_op;
    logic [4:0]        alu_shamt;
    logic              alu_flags_en;
    logic [4:0]        alu_flags_sel;
    logic              alu_cin;
    logic [15:0]       alu_out;
    logic [4:0]        alu_flags;
    logic [15:0]       ir_out;

    cpu_fsm #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc_next(pc_next),
        .imem_dout(imem_dout), .imem_en(imem_en), .imem_addr(imem_addr),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_flags_en(alu_flags_en),
        .alu_flags_sel(alu_flags_sel), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_flags(alu_flags), .ir_out(ir_out)
    );

    // ---------------- behavioural datapath ----------------
    logic [15:0] pc_reg;
    logic [15:0] regs [16];
    logic [15:0] dmem [DEPTH];
    logic [15:0] prog [DEPTH];

    assign pc_in      = pc_reg;
    assign rf_ra_data = regs[rf_ra_addr];
    assign rf_rb_data = regs[rf_rb_addr];

    always @(posedge clk) begin
        if (rst) pc_reg <= 16'h0000;
        else if (pc_en) pc_reg <= pc_next;
        if (tb_clr) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) dmem[i] <= 16'h0000;
        end else begin
            if (rf_we) regs[rf_waddr] <= rf_wdata;
            if (dmem_en) begin
                if (dmem_we) dmem[dmem_addr] <= dmem_din;
                else         dmem_dout <= dmem[dmem_addr];
            end
        end
        if (imem_en) imem_dout <= prog[imem_addr];
    end

    // ALU: produces all five flags for every op so that the DUT's mask matters
    always_comb begin
        logic [16:0] s;
        s         = 17'd0;
        alu_out   = 16'h0000;
        alu_flags = 5'b00000;
        case (alu_op)
            c_ALU_AND: alu_out = rf_ra_data & rf_rb_data;
            c_ALU_OR:  alu_out = rf_ra_data | rf_rb_data;
            c_ALU_XOR: alu_out = rf_ra_data ^ rf_rb_data;
            c_ALU_MOV: alu_out = rf_rb_data;
            c_ALU_SLL: alu_out = rf_ra_data << alu_shamt;
            c_ALU_SRL: alu_out = rf_ra_data >> alu_shamt;
            c_ALU_ADD: begin
                s = {1'b0, rf_ra_data} + {1'b0, rf_rb_data};
                alu_out = s[15:0];
                alu_flags[4] = s[16];
                alu_flags[2] = (rf_ra_data[15] == rf_rb_data[15]) && (s[15] != rf_ra_data[15]);
            end
            c_ALU_SUB, c_ALU_CMP: begin
                s = {1'b0, rf_ra_data} - {1'b0, rf_rb_data};
                alu_out = s[15:0];
                alu_flags[4] = s[16];
                alu_flags[2] = (rf_ra_data[15] != rf_rb_data[15]) && (s[15] != rf_ra_data[15]);
            end
            default: alu_out = 16'h0000;
        endcase
        alu_flags[3] = rf_ra_data < rf_rb_data;
        alu_flags[1] = (alu_out == 16'h0000);
        alu_flags[0] = alu_out[15];
        if (alu_op == c_ALU_CMP) begin
            alu_flags[1] = (rf_ra_data == rf_rb_data);
            alu_flags[0] = $signed(rf_ra_data) < $signed(rf_rb_data);
        end
    end

    // ---------------- ISA-level reference model ----------------
    logic [15:0] m_regs [16];
    logic [15:0] m_dm [DEPTH];
    logic [15:0] m_pc;
    logic [4:0]  m_psr;   // {C,L,F,Z,N}

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0]  last_waddr;
    logic [15:0] last_wdata;
    logic        st_seen;
    logic [ADDR_W-1:0] st_addr;
    logic [15:0] st_din;
    int          last_cyc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        for (int i = 0; i < DEPTH; i++) m_dm[i] = 16'h0000;
        m_pc  = 16'h0000;
        m_psr = 5'b00000;
    endtask

    function automatic logic m_cond(input logic [3:0] c, input logic [4:0] p);
        logic fc, fz, fn;
        fc = p[4]; fz = p[1]; fn = p[0];
        case (c)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h6: return !fn && !fz;
            4'h7: return fn || fz;
            4'hC: return fn;
            4'hD: return !fn;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input logic [15:0] ins, output int cyc, output bit we);
        logic [3:0] op, rd, ext, rs;
        logic [7:0] imm;
        logic [15:0] a, b, nxt;
        int sa, sb, sum;
        op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0]; imm = ins[7:0];
        a = m_regs[rd]; b = m_regs[rs];
        sa = $signed(a); sb = $signed(b);
        nxt = m_pc + 16'd1;
        cyc = 3; we = 0;
        case (op)
            4'h0: case (ext)
                4'h1: begin m_regs[rd] = a & b; we = 1; end
                4'h2: begin m_regs[rd] = a | b; we = 1; end
                4'h3: begin m_regs[rd] = a ^ b; we = 1; end
                4'hD: begin m_regs[rd] = b; we = 1; end
                4'h5: begin
                    m_regs[rd] = a + b; we = 1;
                    m_psr[4] = (int'(a) + int'(b)) > 65535;
                    sum = sa + sb;
                    m_psr[2] = (sum > 32767) || (sum < -32768);
                end
                4'h9: begin
                    m_regs[rd] = a - b; we = 1;
                    m_psr[4] = a < b;
                    sum = sa - sb;
                    m_psr[2] = (sum > 32767) || (sum < -32768);
                end
                4'hB: begin
                    m_psr[3] = a < b;
                    m_psr[1] = a == b;
                    m_psr[0] = sa < sb;
                end
                default: ;
            endcase
            4'hD: begin m_regs[rd] = {8'h00, imm}; we = 1; end
            4'hF: begin m_regs[rd] = {imm, 8'h00}; we = 1; end
            4'h8: if (ext[3:1] == 3'b000) begin
                m_regs[rd] = ext[0] ? (a >> imm[3:0]) : (a << imm[3:0]);
                we = 1;
            end
            4'h4: case (ext)
                4'h0: begin m_regs[rd] = m_dm[b[ADDR_W-1:0]]; we = 1; cyc = 5; end
                4'h4: m_dm[b[ADDR_W-1:0]] = a;
                4'hC: if (m_cond(rd, m_psr)) nxt = b;
                4'h8: begin m_regs[rd] = m_pc + 16'd1; we = 1; nxt = b; end
                default: ;
            endcase
            4'hC: if (m_cond(rd, m_psr)) nxt = m_pc + {{8{imm[7]}}, imm};
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // Execute one instruction on the DUT and compare against the model
    task automatic run_instr(input logic [15:0] ins);
        int exp_cyc, cyc, nwe, bad;
        bit exp_we, done;
        logic cin_seen;
        logic [4:0] psr_before;
        psr_before = m_psr;
        prog[pc_reg[ADDR_W-1:0]] = ins;
        model_step(ins, exp_cyc, exp_we);
        cyc = 0; nwe = 0; done = 0; cin_seen = 1'b0; st_seen = 1'b0;
        while (!done && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) cin_seen = alu_cin;
            if (rf_we) begin nwe++; last_waddr = rf_waddr; last_wdata = rf_wdata; end
            if (dmem_we) begin st_seen = 1'b1; st_addr = dmem_addr; st_din = dmem_din; end
            if (pc_en) done = 1;
        end
        last_cyc = cyc;
        @(posedge clk); #1;
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL timeout ins=%h: pc_en not seen within %0d cycles", ins, cyc); end
        n_tests++;
        if (cyc != exp_cyc) begin n_fail++; $display("FAIL latency ins=%h: got %0d cycles, expected %0d", ins, cyc, exp_cyc); end
        n_tests++;
        if (nwe != (exp_we ? 1 : 0)) begin n_fail++; $display("FAIL rf_we_count ins=%h: got %0d, expected %0d", ins, nwe, exp_we ? 1 : 0); end
        n_tests++;
        if (cin_seen !== psr_before[4]) begin n_fail++; $display("FAIL alu_cin ins=%h: got %b, expected %b", ins, cin_seen, psr_before[4]); end
        n_tests++;
        if (pc_reg !== m_pc) begin n_fail++; $display("FAIL pc ins=%h: got %h, expected %h", ins, pc_reg, m_pc); end
        bad = -1;
        for (int i = 0; i < 16; i++) if (bad < 0 && regs[i] !== m_regs[i]) bad = i;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL regs ins=%h: r%0d got %h, expected %h", ins, bad, regs[bad], m_regs[bad]); end
        bad = -1;
        for (int i = 0; i < DEPTH; i++) if (bad < 0 && dmem[i] !== m_dm[i]) bad = i;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL dmem ins=%h: [%0d] got %h, expected %h", ins, bad, dmem[bad], m_dm[bad]); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; tb_clr = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({pc_en, rf_we, dmem_en, dmem_we, alu_flags_en, imem_en} !== 6'b0) begin
            n_fail++; $display("FAIL reset_enables: got %b, expected 000000", {pc_en, rf_we, dmem_en, dmem_we, alu_flags_en, imem_en});
        end
        n_tests++;
        if (ir_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h, expected 0000", ir_out); end
        n_tests++;
        if ({pc_next, rf_wdata, dmem_din, dmem_addr, imem_addr, alu_op, alu_flags_sel} !== '0) begin
            n_fail++; $display("FAIL reset_buses: got %h %h %h, expected all zero", pc_next, rf_wdata, dmem_din);
        end
        @(posedge clk); #1;
        rst = 1'b0; tb_clr = 1'b0;
    endtask

    task automatic test_basic();
        run_instr(16'hD103);                       // MOVI r1,3
        n_tests++;
        if (regs[1] !== 16'h0003) begin n_fail++; $display("FAIL movi_r1: got %h, expected 0003", regs[1]); end
        n_tests++;
        if (pc_reg !== 16'h0001 || last_cyc != 3) begin n_fail++; $display("FAIL movi_pc: got pc=%h cyc=%0d, expected pc=0001 cyc=3", pc_reg, last_cyc); end
        run_instr(16'hD204);                       // MOVI r2,4
        run_instr(16'h0152);                       // ADD r1,r2
        n_tests++;
        if (last_waddr !== 4'd1 || last_wdata !== 16'h0007) begin
            n_fail++; $display("FAIL add_wb: got r%0d=%h, expected r1=0007", last_waddr, last_wdata);
        end
    endtask

    task automatic test_load_store();
        run_instr(16'hD7FF);                       // MOVI r7,0xFF
        run_instr(16'hD320);                       // MOVI r3,0x20
        run_instr(16'h4743);                       // STOR r7,r3 -> mem[0x20]=0x00FF
        run_instr(16'h4403);                       // LOAD r4,r3
        n_tests++;
        if (regs[4] !== 16'h00FF || last_cyc != 5) begin n_fail++; $display("FAIL load: got r4=%h cyc=%0d, expected 00ff cyc=5", regs[4], last_cyc); end
        run_instr(16'h4143);                       // STOR r1,r3
        n_tests++;
        if (!st_seen || st_addr !== 9'h020 || st_din !== 16'h0007) begin
            n_fail++; $display("FAIL stor: got we=%b addr=%h din=%h, expected 1 020 0007", st_seen, st_addr, st_din);
        end
    endtask

    task automatic test_jumps();
        run_instr(16'hD50A);                       // MOVI r5,0x0A
        run_instr(16'h4EC5);                       // JCOND UC,r5
        n_tests++;
        if (pc_reg !== 16'h000A) begin n_fail++; $display("FAIL jcond_uc: got pc=%h, expected 000a", pc_reg); end
        run_instr(16'hD803);                       // MOVI r8,3
        run_instr(16'h4EC8);                       // JCOND UC,r8 -> pc 3
        run_instr(16'h4685);                       // JAL r6,r5
        n_tests++;
        if (regs[6] !== 16'h0004 || pc_reg !== 16'h000A) begin
            n_fail++; $display("FAIL jal: got r6=%h pc=%h, expected 0004 000a", regs[6], pc_reg);
        end
    endtask

    task automatic test_branch();
        run_instr(16'hD906);                       // MOVI r9,6
        run_instr(16'h4EC9);                       // JCOND UC,r9 -> pc 6
        run_instr(16'h01B1);                       // CMP r1,r1 at pc 6
        run_instr(16'hC0FE);                       // BCOND EQ,-2 at pc 7
        n_tests++;
        if (pc_reg !== 16'h0005) begin n_fail++; $display("FAIL bcond_eq: got pc=%h, expected 0005", pc_reg); end
        run_instr(16'hD907);                       // MOVI r9,7 at pc 5
        run_instr(16'h4EC9);                       // JCOND UC,r9 -> pc 7
        run_instr(16'hC1FE);                       // BCOND NE,-2 at pc 7
        n_tests++;
        if (pc_reg !== 16'h0008) begin n_fail++; $display("FAIL bcond_ne: got pc=%h, expected 0008", pc_reg); end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] rd, rs, c;
        logic [7:0] imm;
        logic [3:0] exts [8];
        exts = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'h7};
        rd = 4'($urandom_range(0, 15)); rs = 4'($urandom_range(0, 15));
        imm = 8'($urandom_range(0, 255));
        c = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 11))
            0:       return {4'hD, rd, imm};
            1:       return {4'hF, rd, imm};
            2, 3:    return {4'h0, rd, exts[$urandom_range(0, 7)], rs};
            4:       return {4'h8, rd, 3'b000, imm[4], imm[3:0]};
            5:       return {4'h4, rd, 4'h0, rs};
            6:       return {4'h4, rd, 4'h4, rs};
            7:       return {4'h4, c, 4'hC, rs};
            8:       return {4'h4, rd, 4'h8, rs};
            9:       return {4'hC, c, imm};
            10:      return {4'h0, rd, 4'hB, rs};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) run_instr(rand_instr());
    endtask

    task automatic test_reset_abort();
        logic [15:0] keep;
        run_instr(16'hD111);                       // MOVI r1,0x11
        keep = regs[1];
        prog[pc_reg[ADDR_W-1:0]] = 16'hD155;       // MOVI r1,0x55, to be aborted
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (rf_we !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL abort_gate: got rf_we=%b pc_en=%b, expected 0 0", rf_we, pc_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = 16'h0000; m_psr = 5'b00000;
        n_tests++;
        if (regs[1] !== keep || ir_out !== 16'h0000 || pc_reg !== 16'h0000) begin
            n_fail++; $display("FAIL abort_state: got r1=%h ir=%h pc=%h, expected %h 0000 0000", regs[1], ir_out, pc_reg, keep);
        end
        run_instr(16'hDA42);                       // MOVI r10,0x42 from pc 0
        n_tests++;
        if (regs[10] !== 16'h0042 || pc_reg !== 16'h0001) begin
            n_fail++; $display("FAIL after_abort: got r10=%h pc=%h, expected 0042 0001", regs[10], pc_reg);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) prog[i] = 16'h0000;
        test_reset();
        test_basic();
        test_load_store();
        test_jumps();
        test_branch();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_fsm.md
# cpu_fsm

Multicycle control unit for the stage-3 16-bit processor. It fetches instructions from port A of the shared dual-port BRAM and decodes them. It sequences the register file, ALU and data port (port B) of the same BRAM, and computes the next PC for the external PC register. All datapath blocks (PC register, BRAM, register file, ALU) sit outside this block; it only drives their controls and selects write-back data.

## Interface
Parameters:
- ADDR_W, 9, BRAM word-address width (imem/dmem address = low ADDR_W bits).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  16  current PC from the PC register.
- pc_en  out  1  load pc_next into the PC register this edge.
- pc_next  out  16  next PC value.
- imem_dout  in  16  instruction word; valid one cycle after its address.
- imem_en  out  1  instruction-port enable.
- imem_addr  out  ADDR_W  instruction address, equal to pc_in[ADDR_W-1:0].
- dmem_en, dmem_we  out  1 each  data-port enable and write enable.
- dmem_addr  out  ADDR_W  data address.
- dmem_din  out  16  store data.
- dmem_dout  in  16  load data; valid one cycle after its address.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  4  register-file write address.
- rf_wdata  out  16  register-file write data.
- rf_ra_addr, rf_rb_addr  out  4 each  read addresses.
- rf_ra_data, rf_rb_data  in  16 each  combinational read data. These also feed ALU inputs a and b.
- alu_op  out  5  ALU operation code.
- alu_shamt  out  5  shift amount.
- alu_flags_en  out  1  ALU may update flags.
- alu_flags_sel  out  5  mask of flags to update.
- alu_cin  out  1  carry-in, equal to PSR.C.
- alu_out  in  16  ALU result.
- alu_flags  in  5  ALU flags {C,L,F,Z,N} in bits [4:0].
- ir_out  out  16  current instruction register, for debug.

## Operation
- Instruction fields: op=[15:12], rd=[11:8], ext=[7:4], rs=[3:0], imm8=[7:0].
- R-type (op 0000): operation is rd = rd OP rs. rf_ra_addr=rd, rf_rb_addr=rs, rf_wdata=alu_out, rf_waddr=rd.
  - ext 0001 AND, 0010 OR, 0011 XOR: no flag update.
  - ext 0101 ADD, 1001 SUB: flags_sel=5'b10100 (C,F).
  - ext 1011 CMP: no register write; flags_sel=5'b01011 (L,Z,N).
  - ext 1101 MOV: no flag update.
  - Any other ext is a NOP.
- MOVI (op 1101): rd = zero-extended imm8; ALU not used.
- LUI (op 1111): rd = {imm8, 8'h00}.
- LSHI (op 1000, ext[3:1]=000): shifts rd by imm[3:0]. ext[0]=0 selects left, 1 selects right. alu_shamt={1'b0,imm[3:0]}.
- Memory and jump instructions (op 0100):
  - ext 0000 LOAD: rd = mem[rs].
  - ext 0100 STOR: mem[rs] = rd. rf_ra_addr=rd and dmem_din=rf_ra_data.
  - ext 1100 JCOND: PC = rs if cond(rd) holds.
  - ext 1000 JAL: rd = pc_in+1, PC = rs.
- BCOND (op 1100): PC = pc_in + sext(imm8) if cond(rd) holds.
- Condition codes (field rd):
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0110 GT: !N&!Z.
  - 0111 LE: N|Z.
  - 1100 LT: N.
  - 1101 GE: !N.
  - 1110 UC: always.
  - All others: never.
- PSR: 5-bit internal register. Bits selected by alu_flags_sel are loaded from alu_flags in EXEC when alu_flags_en=1.
- ALU op codes: fixed in the shared package.
- Undefined opcodes execute as NOP: PC advances by 1, no writes.
- pc_next is pc_in+1 unless a taken branch/jump overrides it. Arithmetic wraps modulo 2^16.

## Timing
- States: FETCH -> DECODE -> EXEC -> (MEM -> WB for LOAD only) -> FETCH.
- FETCH: drives imem_en=1 and imem_addr. DECODE: IR <= imem_dout.
- EXEC: ALU, immediate and JAL write-backs (rf_we=1); STOR write (dmem_en=dmem_we=1); branch decision; pc_en=1. LOAD instead drives dmem_en=1, dmem_addr=rf_rb_data in EXEC.
- LOAD: MEM waits one cycle for read data. WB drives rf_wdata=dmem_dout, rf_we=1, pc_en=1.
- Latency: 3 cycles per instruction, 5 for LOAD.
- pc_en and rf_we are each high for exactly one cycle per instruction.
- Reset:
  - state=FETCH; IR=0; PSR=0.
  - pc_en, rf_we, dmem_en, dmem_we, alu_flags_en = 0.
  - All buses = 0.
- Reset asserted mid-instruction aborts the instruction with no write.

## Structure
- Package cpu_pkg: opcode/ext constants, condition codes, ALU op codes, flag bit indices, state enum.
- Natural sub-module: cond_eval (condition code, PSR -> taken).

## Test plan
- Reset, then MOVI r1,3 at address 0 -> r1=0x0003 after 3 cycles; pc=1.
- MOVI r2,4; ADD r1,r2 -> rf_wdata=0x0007 written to r1 in EXEC.
- Preload mem[0x20]=0x00FF, r3=0x20; LOAD r4,r3 -> r4=0x00FF after 5 cycles.
- STOR r1,r3 -> dmem_we=1, dmem_addr=0x20, dmem_din=r1 value.
- r5=0x000A; JCOND UC,r5 -> pc=0x000A. JAL r6,r5 at pc 3 -> r6=4.
- CMP r1,r1 then BCOND EQ,-2 at pc 7 -> pc=5. BCOND NE at the same point -> pc=8.
